// File: rtl/riscv_pkg.sv
// Shared RV32 decode types and helpers for the front-end slice.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package riscv_pkg;

  localparam int XLEN    = 32;
  localparam int RS1_LSB = 15;
  localparam int RS2_LSB = 20;

  typedef enum logic [6:0] {
    OP_LUI    = 7'b0110111,
    OP_AUIPC  = 7'b0010111,
    OP_JAL    = 7'b1101111,
    OP_JALR   = 7'b1100111,
    OP_BRANCH = 7'b1100011,
    OP_LOAD   = 7'b0000011,
    OP_STORE  = 7'b0100011,
    OP_I_TYPE = 7'b0010011,
    OP_R_TYPE = 7'b0110011
  } opcode_t;

  // One queued fetch: instruction word plus the PC it came from.
  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_ent_t;

  function automatic logic uses_rs1(input opcode_t op);
    case (op)
      OP_R_TYPE, OP_I_TYPE, OP_LOAD, OP_STORE, OP_BRANCH, OP_JALR: uses_rs1 = 1'b1;
      default:                                                      uses_rs1 = 1'b0;
    endcase
  endfunction

  function automatic logic uses_rs2(input opcode_t op);
    case (op)
      OP_R_TYPE, OP_STORE, OP_BRANCH: uses_rs2 = 1'b1;
      default:                        uses_rs2 = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Generic synchronous FIFO with occupancy count and synchronous clear.
// Latency: a write at edge N is readable at the head from edge N+1.
// Backpressure: writes while full and reads while empty are ignored; clear wins over both.
module sync_fifo #(
  parameter  int W     = 8,
  parameter  int DEPTH = 2,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          wr_en,
  input  logic [W-1:0]  wr_dat,
  input  logic          rd_en,
  output logic [W-1:0]  rd_dat,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push;
  logic          pop;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign push  = wr_en && !full && !clr;
  assign pop   = rd_en && !empty && !clr;

  // Head is zero when nothing is queued so downstream never sees stale data.
  assign rd_dat = empty ? '0 : mem[rd_ptr];

  // Storage carries no reset; validity is tracked by count alone.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_dat;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/decode_issue_ctrl.sv
// Fetch-to-decode queue: buffers fetches, presents the head, issues into ID/EX with load-use bubbles.
// Latency: an instruction enqueued at edge N can issue in the cycle after edge N.
// Backpressure: ex_ready=0 or a load-use hazard holds the head; if_ready drops only when the queue is full.
module decode_issue_ctrl
  import riscv_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             if_valid,
  output logic             if_ready,
  input  logic [XLEN-1:0]  if_instr,
  input  logic [XLEN-1:0]  if_pc,
  input  logic             flush,
  input  logic             ex_is_load,
  input  logic [4:0]       ex_rd,
  input  logic             ex_ready,
  output logic             id_valid,
  output logic [XLEN-1:0]  id_instr,
  output logic [XLEN-1:0]  id_pc,
  output opcode_t          id_opcode,
  output logic             hazard,
  output logic [CNT_W-1:0] bubble_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_ent_t     wr_ent;
  fetch_ent_t     head;
  logic [AW:0]    q_count;
  logic           q_full;
  logic           q_empty;
  logic           enq;
  logic [4:0]     rs1;
  logic [4:0]     rs2;
  logic           rs1_hit;
  logic           rs2_hit;
  logic [CNT_W:0] flush_sum;

  assign wr_ent.instr = if_instr;
  assign wr_ent.pc    = if_pc;

  // if_ready comes straight from the registered full flag, so fetch never sees a path from EX.
  assign if_ready = !q_full;
  assign enq      = if_valid && if_ready && !flush;

  sync_fifo #(
    .W     ($bits(fetch_ent_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (flush),
    .wr_en  (enq),
    .wr_dat (wr_ent),
    .rd_en  (id_valid),
    .rd_dat (head),
    .count  (q_count),
    .full   (q_full),
    .empty  (q_empty)
  );

  assign id_instr  = head.instr;
  assign id_pc     = head.pc;
  assign id_opcode = opcode_t'(head.instr[6:0]);

  assign rs1     = head.instr[RS1_LSB +: 5];
  assign rs2     = head.instr[RS2_LSB +: 5];
  assign rs1_hit = uses_rs1(id_opcode) && (rs1 == ex_rd);
  assign rs2_hit = uses_rs2(id_opcode) && (rs2 == ex_rd);

  // A flush squashes everything, including the bubble that would otherwise be reported.
  assign hazard   = !q_empty && !flush && ex_is_load && (ex_rd != 5'd0) && (rs1_hit || rs2_hit);
  assign id_valid = !q_empty && !hazard && ex_ready && !flush;

  assign flush_sum = {1'b0, flush_cnt} + (CNT_W+1)'(q_count);

  // Saturating performance counters: bubbles actually inserted, and entries thrown away by redirects.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bubble_cnt <= '0;
      flush_cnt  <= '0;
    end else begin
      if (hazard && ex_ready && (bubble_cnt != '1)) bubble_cnt <= bubble_cnt + 1'b1;
      if (flush) flush_cnt <= flush_sum[CNT_W] ? '1 : flush_sum[CNT_W-1:0];
    end
  end

endmodule

// File: tb/tb_decode_issue_ctrl.sv
module tb_decode_issue_ctrl;
  import riscv_pkg::*;

  localparam int DEPTH = 2;
  localparam int CNT_W = 4;
  localparam logic [63:0] CMAX = 64'd15;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             if_valid = 1'b0;
  logic             if_ready;
  logic [XLEN-1:0]  if_instr = '0;
  logic [XLEN-1:0]  if_pc = '0;
  logic             flush = 1'b0;
  logic             ex_is_load = 1'b0;
  logic [4:0]       ex_rd = '0;
  logic             ex_ready = 1'b0;
  logic             id_valid;
  logic [XLEN-1:0]  id_instr;
  logic [XLEN-1:0]  id_pc;
  opcode_t          id_opcode;
  logic             hazard;
  logic [CNT_W-1:0] bubble_cnt;
  logic [CNT_W-1:0] flush_cnt;

  decode_issue_ctrl #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .if_valid   (if_valid),
    .if_ready   (if_ready),
    .if_instr   (if_instr),
    .if_pc      (if_pc),
    .flush      (flush),
    .ex_is_load (ex_is_load),
    .ex_rd      (ex_rd),
    .ex_ready   (ex_ready),
    .id_valid   (id_valid),
    .id_instr   (id_instr),
    .id_pc      (id_pc),
    .id_opcode  (id_opcode),
    .hazard     (hazard),
    .bubble_cnt (bubble_cnt),
    .flush_cnt  (flush_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Scoreboard: model queue of {instr, pc}; head is what the DUT must present.
  logic [63:0] exp_q[$];
  logic [63:0] m_bub = '0;
  logic [63:0] m_flush = '0;
  logic        last_acc = 1'b0;
  int          issued = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic m_rs1(input logic [6:0] op);
    return op == 7'h33 || op == 7'h13 || op == 7'h03 || op == 7'h23 || op == 7'h63 || op == 7'h67;
  endfunction

  function automatic logic m_rs2(input logic [6:0] op);
    return op == 7'h33 || op == 7'h23 || op == 7'h63;
  endfunction

  task automatic setin(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                       input logic er, input logic ld, input logic [4:0] rd, input logic fl);
    if_valid = v; if_instr = ins; if_pc = pc;
    ex_ready = er; ex_is_load = ld; ex_rd = rd; flush = fl;
  endtask

  // Compare the DUT against the model at the negedge, advance the model, move to just after posedge.
  task automatic tick();
    logic [63:0] h;
    logic [31:0] hi;
    logic        m_hz, m_iv, m_acc, nempty;
    int          sz;
    logic [63:0] sum;
    @(negedge clk);
    sz     = exp_q.size();
    nempty = (sz != 0);
    h      = nempty ? exp_q[0] : 64'd0;
    hi     = h[63:32];
    m_acc  = if_valid && (sz < DEPTH) && !flush;
    m_hz   = nempty && !flush && ex_is_load && (ex_rd != 5'd0) &&
             ((m_rs1(hi[6:0]) && hi[19:15] == ex_rd) || (m_rs2(hi[6:0]) && hi[24:20] == ex_rd));
    m_iv   = nempty && !m_hz && ex_ready && !flush;
    chk("if_ready", {63'd0, if_ready}, {63'd0, sz < DEPTH});
    chk("hazard",   {63'd0, hazard},   {63'd0, m_hz});
    chk("id_valid", {63'd0, id_valid}, {63'd0, m_iv});
    chk("head",     {id_instr, id_pc}, h);
    if (rst_n) begin
      if (flush) begin
        sum     = m_flush + 64'(sz);
        m_flush = (sum > CMAX) ? CMAX : sum;
        exp_q.delete();
      end else begin
        if (m_iv) begin void'(exp_q.pop_front()); issued++; end
        if (m_acc) exp_q.push_back({if_instr, if_pc});
        if (m_hz && ex_ready && m_bub != CMAX) m_bub++;
      end
    end
    last_acc = m_acc && rst_n;
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    // Reset values
    #1;
    chk("rst_if_ready", {63'd0, if_ready}, 64'd1);
    chk("rst_id_valid", {63'd0, id_valid}, 64'd0);
    chk("rst_hazard",   {63'd0, hazard},   64'd0);
    chk("rst_id_instr", {32'd0, id_instr}, 64'd0);
    chk("rst_bubble",   {60'd0, bubble_cnt}, 64'd0);
    chk("rst_flush",    {60'd0, flush_cnt},  64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Single addi issues the cycle after it is enqueued
    setin(1, 32'h00500093, 32'h0, 1, 0, 0, 0); tick();
    setin(0, 32'h0, 32'h0, 1, 0, 0, 0); #1;
    chk("addi_valid",  {63'd0, id_valid}, 64'd1);
    chk("addi_opcode", {57'd0, id_opcode}, 64'h13);
    chk("addi_pc",     {32'd0, id_pc}, 64'h0);
    tick(); tick();
    chk("addi_issued", 64'(issued), 64'd1);

    // Backpressure: two fill the queue, third waits on fetch
    setin(1, 32'h00100113, 32'h0, 0, 0, 0, 0); tick();
    setin(1, 32'h00200193, 32'h4, 0, 0, 0, 0); tick();
    chk("full_if_ready", {63'd0, if_ready}, 64'd0);
    setin(1, 32'h00300213, 32'h8, 0, 0, 0, 0); tick();
    n = 0;
    do begin
      setin(1, 32'h00300213, 32'h8, 1, 0, 0, 0); tick(); n++;
    end while (!last_acc && n < 10);
    chk("third_accepted", {63'd0, last_acc}, 64'd1);
    setin(0, 32'h0, 32'h0, 1, 0, 0, 0);
    repeat (4) tick();
    chk("bp_issued", 64'(issued), 64'd4);

    // Load-use on rs2 of add x3,x1,x2
    setin(1, 32'h002081B3, 32'h10, 1, 0, 0, 0); tick();
    setin(0, 32'h0, 32'h0, 1, 1, 5'd2, 0); #1;
    chk("lu_hazard", {63'd0, hazard}, 64'd1);
    chk("lu_valid",  {63'd0, id_valid}, 64'd0);
    tick();
    chk("lu_bubble", {60'd0, bubble_cnt}, 64'd1);
    setin(0, 32'h0, 32'h0, 1, 0, 5'd2, 0); #1;
    chk("lu_release", {63'd0, id_valid}, 64'd1);
    tick();
    // Same instruction, load to x0: never a hazard
    setin(1, 32'h002081B3, 32'h14, 1, 0, 0, 0); tick();
    setin(0, 32'h0, 32'h0, 1, 1, 5'd0, 0); #1;
    chk("x0_hazard", {63'd0, hazard}, 64'd0);
    tick();
    // LUI whose bits 19:15 equal ex_rd: no source registers
    setin(1, 32'h123450B7, 32'h18, 1, 0, 0, 0); tick();
    setin(0, 32'h0, 32'h0, 1, 1, 5'd8, 0); #1;
    chk("lui_hazard", {63'd0, hazard}, 64'd0);
    chk("lui_valid",  {63'd0, id_valid}, 64'd1);
    tick();

    // Flush with a full queue and a same-cycle fetch
    setin(1, 32'h00400293, 32'h100, 0, 0, 0, 0); tick();
    setin(1, 32'h00500313, 32'h104, 0, 0, 0, 0); tick();
    setin(1, 32'h00600393, 32'h108, 1, 0, 0, 1); #1;
    chk("fl_valid", {63'd0, id_valid}, 64'd0);
    tick();
    setin(0, 32'h0, 32'h0, 1, 0, 0, 0); #1;
    chk("fl_cnt",   {60'd0, flush_cnt}, 64'd2);
    chk("fl_empty", {63'd0, if_ready}, 64'd1);
    chk("fl_drop",  {32'd0, id_pc}, 64'd0);
    tick();

    // Bubble counter saturation
    setin(1, 32'h002081B3, 32'h200, 1, 0, 0, 0); tick();
    setin(0, 32'h0, 32'h0, 1, 1, 5'd1, 0);
    repeat (20) tick();
    chk("bub_sat", {60'd0, bubble_cnt}, CMAX);
    chk("bub_model", {60'd0, bubble_cnt}, m_bub);
    setin(0, 32'h0, 32'h0, 1, 0, 0, 0); tick(); tick();

    // Asynchronous reset with a full queue
    setin(1, 32'h00700413, 32'h300, 0, 0, 0, 0); tick();
    setin(1, 32'h00800493, 32'h304, 0, 0, 0, 0); tick();
    setin(0, 32'h0, 32'h0, 1, 0, 0, 0);
    #1 rst_n = 1'b0;
    #1;
    chk("ar_if_ready", {63'd0, if_ready}, 64'd1);
    chk("ar_id_valid", {63'd0, id_valid}, 64'd0);
    chk("ar_id_instr", {32'd0, id_instr}, 64'd0);
    chk("ar_bubble",   {60'd0, bubble_cnt}, 64'd0);
    chk("ar_flush",    {60'd0, flush_cnt},  64'd0);
    exp_q.delete(); m_bub = '0; m_flush = '0;
    tick();
    rst_n = 1'b1;
    setin(1, 32'h00900513, 32'h400, 1, 0, 0, 0); tick();
    setin(0, 32'h0, 32'h0, 1, 0, 0, 0); tick(); tick();
    chk("post_rst_flush", {60'd0, flush_cnt}, m_flush);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
